mips_prog_loader: RTL and testbench

MIPS_PROG_LOADER -- requirements
Module: mips_prog_loader

---
 rtl/mips_prog_loader.sv | 149 ++++++++++++++
 tb/tb_mips_prog_loader.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_prog_loader.sv
// Serial program loader: hunts for a framed byte stream, assembles big-endian
// 32-bit words into instruction memory and releases the CPU once the frame is complete.
module mips_prog_loader #(
    parameter int          ADDR_W    = 10,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              restart,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_start,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [31:0] DEPTH = 32'd1 << ADDR_W;

    typedef enum logic [2:0] {
        HUNT,
        CNT_HI,
        CNT_LO,
        DATA,
        WRITE,
        DONE,
        ERR
    } state_t;

    state_t          state;
    logic [15:0]     count;
    logic [23:0]     word_sr;
    logic [1:0]      byte_idx;
    logic            accept;
    logic [15:0]     new_count;
    logic [ADDR_W:0] wl_next;

    assign accept    = in_valid & in_ready;
    assign new_count = {count[15:8], in_data};
    assign wl_next   = words_loaded + (ADDR_W+1)'(1);

    // in_ready is registered, so every transition also sets the ready level of its target state.
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            state        <= HUNT;
            in_ready     <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            cpu_start    <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
            count        <= '0;
            word_sr      <= '0;
            byte_idx     <= '0;
        end else begin
            mem_we    <= 1'b0;
            cpu_start <= 1'b0;
            if (restart) begin
                state        <= HUNT;
                in_ready     <= 1'b1;
                done         <= 1'b0;
                err          <= 1'b0;
                words_loaded <= '0;
                word_sr      <= '0;
                byte_idx     <= '0;
            end else begin
                in_ready <= in_ready | (state inside {HUNT, CNT_HI, CNT_LO, DATA});
                case (state)
                    HUNT: begin
                        in_ready <= 1'b1;
                        if (accept && in_data == SYNC_BYTE)
                            state <= CNT_HI;
                    end
                    CNT_HI: begin
                        if (accept) begin
                            count[15:8] <= in_data;
                            state       <= CNT_LO;
                        end
                    end
                    CNT_LO: begin
                        if (accept) begin
                            count        <= new_count;
                            words_loaded <= '0;
                            byte_idx     <= '0;
                            if (new_count == 16'd0) begin
                                state     <= DONE;
                                in_ready  <= 1'b0;
                                done      <= 1'b1;
                                cpu_start <= 1'b1;
                            end else if (32'(new_count) > DEPTH) begin
                                state    <= ERR;
                                in_ready <= 1'b0;
                                err      <= 1'b1;
                            end else begin
                                state <= DATA;
                            end
                        end
                    end
                    DATA: begin
                        if (accept) begin
                            word_sr <= {word_sr[15:0], in_data};
                            if (byte_idx == 2'd3) begin
                                state     <= WRITE;
                                in_ready  <= 1'b0;
                                mem_we    <= 1'b1;
                                mem_addr  <= words_loaded[ADDR_W-1:0];
                                mem_wdata <= {word_sr, in_data};
                                byte_idx  <= '0;
                            end else begin
                                byte_idx <= byte_idx + 2'd1;
                            end
                        end
                    end
                    WRITE: begin
                        words_loaded <= wl_next;
                        if (32'(wl_next) == 32'(count)) begin
                            state     <= DONE;
                            in_ready  <= 1'b0;
                            done      <= 1'b1;
                            cpu_start <= 1'b1;
                        end else begin
                            state    <= DATA;
                            in_ready <= 1'b1;
                        end
                    end
                    DONE: begin
                        in_ready <= 1'b0;
                        done     <= 1'b1;
                    end
                    ERR: begin
                        in_ready <= 1'b0;
                        err      <= 1'b1;
                    end
                    default: begin
                        state    <= HUNT;
                        in_ready <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mips_prog_loader.sv
// Randomized bench for mips_prog_loader: byte streams are parsed by a frame-level
// reference model and the captured memory writes and status flags are compared against it.
module tb_mips_prog_loader;

    localparam int         ADDR_W = 10;
    localparam logic [7:0] SYNC   = 8'hA5;

    logic              clk1 = 1'b0;
    logic              rst_n = 1'b0;
    logic              restart = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_start;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   words_loaded;

    mips_prog_loader #(.ADDR_W(ADDR_W), .SYNC_BYTE(SYNC)) dut (
        .clk1(clk1), .rst_n(rst_n), .restart(restart), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .cpu_start(cpu_start), .done(done), .err(err),
        .words_loaded(words_loaded)
    );

    always #5 clk1 = ~clk1;

    int checks = 0;
    int failures = 0;

    logic [ADDR_W-1:0] got_a[$];
    logic [31:0]       got_d[$];
    int                starts = 0;

    logic [ADDR_W-1:0] exp_a[$];
    logic [31:0]       exp_d[$];
    logic              exp_done;
    logic              exp_err;
    int                exp_words;

    logic [31:0] prog[8] = '{32'h28010078, 32'h0c631800, 32'h20220000, 32'h0c631800,
                             32'h2842002d, 32'h0c631800, 32'h24220001, 32'hc0000000};

    always @(negedge clk1) begin
        if (mem_we) begin
            got_a.push_back(mem_addr);
            got_d.push_back(mem_wdata);
        end
        if (cpu_start) starts++;
    end

    // Frame-level reference: find the marker, read the count, then cut the rest into words.
    task automatic model(input logic [7:0] s[$]);
        int i;
        int cnt;
        i = 0;
        exp_a.delete(); exp_d.delete();
        exp_done = 1'b0; exp_err = 1'b0; exp_words = 0;
        while (i < s.size() && s[i] !== SYNC) i++;
        if (i + 2 >= s.size()) return;
        cnt = {16'd0, s[i+1], s[i+2]};
        i += 3;
        if (cnt > (1 << ADDR_W)) begin
            exp_err = 1'b1;
            return;
        end
        for (int w = 0; w < cnt && i + 3 < s.size(); w++) begin
            exp_a.push_back(ADDR_W'(w));
            exp_d.push_back({s[i], s[i+1], s[i+2], s[i+3]});
            i += 4;
        end
        exp_words = exp_a.size();
        exp_done  = (exp_words == cnt);
    endtask

    task automatic send_byte(input logic [7:0] b, input int maxgap);
        int n;
        repeat ($urandom_range(0, maxgap)) @(negedge clk1);
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk1);
            n++;
        end
        if (!in_ready) begin
            checks++; failures++;
            $display("[TB] FAIL accept_timeout in_ready=%b required 1 (byte %h)", in_ready, b);
        end
        @(negedge clk1);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic send_stream(input logic [7:0] s[$], input int maxgap);
        foreach (s[k]) send_byte(s[k], maxgap);
    endtask

    task automatic do_restart();
        @(negedge clk1);
        restart = 1'b1;
        @(negedge clk1);
        restart = 1'b0;
        got_a.delete(); got_d.delete();
        starts = 0;
    endtask

    task automatic program_stream(output logic [7:0] s[$]);
        s = '{SYNC, 8'h00, 8'h08};
        foreach (prog[k]) begin
            s.push_back(prog[k][31:24]); s.push_back(prog[k][23:16]);
            s.push_back(prog[k][15:8]);  s.push_back(prog[k][7:0]);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk1);
        checks++;
        if (in_ready !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0 ||
            cpu_start !== 1'b0 || done !== 1'b0 || err !== 1'b0 || words_loaded !== '0) begin
            failures++;
            $display("[TB] FAIL reset_state got rdy=%b we=%b a=%h d=%h st=%b dn=%b er=%b wl=%0d required all 0",
                     in_ready, mem_we, mem_addr, mem_wdata, cpu_start, done, err, words_loaded);
        end
        rst_n = 1'b1;
        @(negedge clk1);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_release_ready got=%b required 1", in_ready);
        end
    endtask

    task automatic test_full_program();
        logic [7:0] s[$];
        do_restart();
        program_stream(s);
        model(s);
        send_stream(s, 0);
        repeat (4) @(negedge clk1);
        checks++;
        if (got_a.size() !== exp_a.size()) begin
            failures++;
            $display("[TB] FAIL prog_write_count got=%0d required %0d", got_a.size(), exp_a.size());
        end
        for (int k = 0; k < exp_a.size() && k < got_a.size(); k++) begin
            checks++;
            if (got_a[k] !== exp_a[k] || got_d[k] !== exp_d[k]) begin
                failures++;
                $display("[TB] FAIL prog_write[%0d] got %h:%h required %h:%h", k, got_a[k], got_d[k], exp_a[k], exp_d[k]);
            end
        end
        checks++;
        if (done !== exp_done || err !== 1'b0 || starts !== 1 || words_loaded !== 11'(exp_words) || in_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL prog_status got dn=%b er=%b starts=%0d wl=%0d rdy=%b required 1 0 1 %0d 0",
                     done, err, starts, words_loaded, in_ready, exp_words);
        end
    endtask

    task automatic test_junk_sync();
        logic [7:0] s[$];
        do_restart();
        s = '{8'h3C, 8'h00, SYNC, 8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        model(s);
        send_stream(s, 0);
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== '0 || mem_wdata !== 32'hDEADBEEF || in_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL junk_write_latency got we=%b a=%h d=%h rdy=%b required 1 000 deadbeef 0",
                     mem_we, mem_addr, mem_wdata, in_ready);
        end
        @(negedge clk1);
        checks++;
        if (mem_we !== 1'b0 || cpu_start !== 1'b1 || done !== 1'b1 || mem_wdata !== 32'hDEADBEEF) begin
            failures++;
            $display("[TB] FAIL junk_done_entry got we=%b st=%b dn=%b d=%h required 0 1 1 deadbeef",
                     mem_we, cpu_start, done, mem_wdata);
        end
        repeat (3) @(negedge clk1);
        checks++;
        if (got_a.size() !== exp_a.size() || got_d.size() != 1 || got_d[0] !== exp_d[0] || starts !== 1 || done !== 1'b1) begin
            failures++;
            $display("[TB] FAIL junk_summary got writes=%0d starts=%0d dn=%b required %0d 1 1",
                     got_a.size(), starts, done, exp_a.size());
        end
    endtask

    task automatic test_zero_count();
        do_restart();
        send_stream('{SYNC, 8'h00, 8'h00}, 0);
        checks++;
        if (cpu_start !== 1'b1 || done !== 1'b1 || in_ready !== 1'b0 || mem_we !== 1'b0) begin
            failures++;
            $display("[TB] FAIL zero_entry got st=%b dn=%b rdy=%b we=%b required 1 1 0 0", cpu_start, done, in_ready, mem_we);
        end
        repeat (5) @(negedge clk1);
        checks++;
        if (cpu_start !== 1'b0 || done !== 1'b1 || starts !== 1 || got_a.size() !== 0 || words_loaded !== '0) begin
            failures++;
            $display("[TB] FAIL zero_hold got st=%b dn=%b starts=%0d writes=%0d wl=%0d required 0 1 1 0 0",
                     cpu_start, done, starts, got_a.size(), words_loaded);
        end
    endtask

    task automatic test_oversize();
        logic [7:0] s[$];
        do_restart();
        s = '{SYNC, 8'h04, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
        model(s);
        send_stream(s[0:2], 0);
        repeat (4) @(negedge clk1);
        checks++;
        if (err !== exp_err || done !== 1'b0 || in_ready !== 1'b0 || got_a.size() !== 0 || starts !== 0) begin
            failures++;
            $display("[TB] FAIL oversize_err got er=%b dn=%b rdy=%b writes=%0d starts=%0d required %b 0 0 0 0",
                     err, done, in_ready, got_a.size(), starts, exp_err);
        end
        do_restart();
        checks++;
        if (err !== 1'b0 || in_ready !== 1'b1 || words_loaded !== '0) begin
            failures++;
            $display("[TB] FAIL oversize_restart got er=%b rdy=%b wl=%0d required 0 1 0", err, in_ready, words_loaded);
        end
    endtask

    task automatic test_abort_restart();
        logic [7:0] s[$];
        do_restart();
        send_stream('{SYNC, 8'h00, 8'h02, 8'h11, 8'h22}, 1);
        do_restart();
        s = '{SYNC, 8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04};
        model(s);
        send_stream(s, 1);
        repeat (4) @(negedge clk1);
        checks++;
        if (got_a.size() !== 1 || got_a[0] !== exp_a[0] || got_d[0] !== exp_d[0] || done !== 1'b1 || starts !== 1) begin
            failures++;
            $display("[TB] FAIL abort_frame got writes=%0d dn=%b starts=%0d required 1 1 1", got_a.size(), done, starts);
        end
    endtask

    task automatic test_restart_priority();
        logic [7:0] s[$];
        do_restart();
        @(negedge clk1);
        restart  = 1'b1;
        in_valid = 1'b1;
        in_data  = SYNC;
        @(negedge clk1);
        restart  = 1'b0;
        in_valid = 1'b0;
        s = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
        model(s);
        send_stream(s, 0);
        repeat (3) @(negedge clk1);
        checks++;
        if (got_a.size() !== exp_a.size() || done !== exp_done || in_ready !== 1'b1 || starts !== 0) begin
            failures++;
            $display("[TB] FAIL restart_priority got writes=%0d dn=%b rdy=%b starts=%0d required 0 0 1 0",
                     got_a.size(), done, in_ready, starts);
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] s[$];
        do_restart();
        send_stream('{SYNC, 8'h00, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h55, 8'h66}, 2);
        repeat (2) @(negedge clk1);
        checks++;
        if (got_a.size() !== 1 || got_d[0] !== 32'hAABBCCDD) begin
            failures++;
            $display("[TB] FAIL midframe_first_word got writes=%0d required 1", got_a.size());
        end
        rst_n = 1'b0;
        restart = 1'b1;
        @(negedge clk1);
        checks++;
        if (in_ready !== 1'b0 || mem_we !== 1'b0 || words_loaded !== '0 || mem_wdata !== '0 || done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midframe_reset got rdy=%b we=%b wl=%0d d=%h dn=%b required 0 0 0 0 0",
                     in_ready, mem_we, words_loaded, mem_wdata, done);
        end
        @(negedge clk1);
        rst_n = 1'b1;
        restart = 1'b0;
        @(negedge clk1);
        checks++;
        if (got_a.size() !== 1 || in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL midframe_partial got writes=%0d rdy=%b required 1 1", got_a.size(), in_ready);
        end
        got_a.delete(); got_d.delete(); starts = 0;
        program_stream(s);
        model(s);
        send_stream(s, 3);
        repeat (4) @(negedge clk1);
        checks++;
        if (got_a.size() !== exp_a.size() || starts !== 1 || done !== 1'b1) begin
            failures++;
            $display("[TB] FAIL gap_prog_status got writes=%0d starts=%0d dn=%b required %0d 1 1",
                     got_a.size(), starts, done, exp_a.size());
        end
        for (int k = 0; k < exp_a.size() && k < got_a.size(); k++) begin
            checks++;
            if (got_a[k] !== exp_a[k] || got_d[k] !== exp_d[k]) begin
                failures++;
                $display("[TB] FAIL gap_prog_write[%0d] got %h:%h required %h:%h", k, got_a[k], got_d[k], exp_a[k], exp_d[k]);
            end
        end
    endtask

    task automatic test_max_count();
        logic [7:0] s[$];
        int bad;
        do_restart();
        s = '{SYNC, 8'h04, 8'h00};
        for (int k = 0; k < 4 * (1 << ADDR_W); k++) s.push_back(8'($urandom));
        model(s);
        send_stream(s, 0);
        repeat (4) @(negedge clk1);
        checks++;
        if (got_a.size() !== exp_a.size() || done !== 1'b1 || err !== 1'b0 || starts !== 1 ||
            words_loaded !== 11'(1 << ADDR_W)) begin
            failures++;
            $display("[TB] FAIL max_status got writes=%0d dn=%b er=%b starts=%0d wl=%0d required %0d 1 0 1 %0d",
                     got_a.size(), done, err, starts, words_loaded, exp_a.size(), 1 << ADDR_W);
        end
        bad = 0;
        for (int k = 0; k < exp_a.size() && k < got_a.size(); k++)
            if (got_a[k] !== exp_a[k] || got_d[k] !== exp_d[k]) bad++;
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("[TB] FAIL max_contents got %0d wrong words required 0", bad);
        end
    endtask

    task automatic test_random_frames();
        logic [7:0] s[$];
        logic [7:0] b;
        int cnt;
        for (int f = 0; f < 8; f++) begin
            do_restart();
            s.delete();
            repeat ($urandom_range(0, 3)) begin
                b = 8'($urandom);
                if (b == SYNC) b = 8'h00;
                s.push_back(b);
            end
            cnt = $urandom_range(1, 12);
            s.push_back(SYNC); s.push_back(8'h00); s.push_back(8'(cnt));
            repeat (4 * cnt) s.push_back(8'($urandom));
            model(s);
            send_stream(s, 2);
            repeat (4) @(negedge clk1);
            checks++;
            if (got_a.size() !== exp_a.size() || done !== exp_done || starts !== 1 || words_loaded !== 11'(exp_words)) begin
                failures++;
                $display("[TB] FAIL rand%0d_status got writes=%0d dn=%b starts=%0d wl=%0d required %0d %b 1 %0d",
                         f, got_a.size(), done, starts, words_loaded, exp_a.size(), exp_done, exp_words);
            end
            for (int k = 0; k < exp_a.size() && k < got_a.size(); k++) begin
                checks++;
                if (got_a[k] !== exp_a[k] || got_d[k] !== exp_d[k]) begin
                    failures++;
                    $display("[TB] FAIL rand%0d_write[%0d] got %h:%h required %h:%h", f, k, got_a[k], got_d[k], exp_a[k], exp_d[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_program();
        test_junk_sync();
        test_zero_count();
        test_oversize();
        test_abort_restart();
        test_restart_priority();
        test_reset_midframe();
        test_max_count();
        test_random_frames();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
